// File: rtl/ecall_ctrl_pkg.sv
// ecall_ctrl_pkg
// Shared definitions for the ECALL sequencing path.
// Contents:
//   ECALL           opcode of the environment-call instruction
//   svc_t           service codes carried in a7 (print int, read int, exit)
//   state_t         sequencer states
//   decode_svc()    maps a raw a7 value onto svc_t; anything unknown is SVC_NONE
package ecall_ctrl_pkg;

  localparam logic [6:0] ECALL = 7'b1110011;

  typedef enum logic [3:0] {
    SVC_NONE      = 4'd0,
    SVC_PRINT_INT = 4'd1,
    SVC_READ_INT  = 4'd5,
    SVC_EXIT      = 4'd10
  } svc_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RELEASE,
    WAIT_PRESS,
    WRITE,
    RESUME,
    HALT
  } state_t;

  // The full 32-bit a7 is compared, so e.g. 32'h0000_0015 is not mistaken
  // for a read request just because its low nibble is 5.
  function automatic svc_t decode_svc(input logic [31:0] code);
    svc_t result;
    result = SVC_NONE;
    case (code)
      32'd1:   result = SVC_PRINT_INT;
      32'd5:   result = SVC_READ_INT;
      32'd10:  result = SVC_EXIT;
      default: result = SVC_NONE;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/ecall_ctrl_debounce.sv
// btn_debounce
// Debounces a raw push-button and reports a one-cycle rising edge of the
// accepted level.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   raw    in   raw button level
//   level  out  accepted (debounced) level
//   rise   out  high for the single cycle after level goes 0 -> 1
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             level_prev;

  // The counter tracks how many consecutive samples have disagreed with the
  // accepted level. Any agreeing sample throws the count away, so a bounce
  // shorter than DEBOUNCE_CYCLES never flips the level. The sample that
  // finds the counter at its last value is the DEBOUNCE_CYCLES-th one in a
  // row, so the level flips there and the count starts over; it therefore
  // never climbs past CNT_LAST and cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      level      <= 1'b0;
      level_prev <= 1'b0;
    end else begin
      level_prev <= level;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= raw;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_prev;

endmodule

// File: rtl/ecall_ctrl.sv
// ecall_ctrl
// Sequences the ECALL system-call path of the single-cycle core: freezes the
// core, waits for a fresh confirm press, performs the service chosen by a7
// (print int, read int, exit) and then releases the core.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   opcode       in   opcode of the current instruction
//   a7           in   service code
//   a0           in   print argument
//   confirm_btn  in   raw confirm button, active-high
//   sw_data      in   board switches (SW_WIDTH bits, SW_WIDTH <= 32)
//   stop_flag    out  freezes PC and register-file writes while high
//   io_wdata     out  sign-extended switch value for a0 (W_data_io)
//   io_wen       out  one-cycle a0 write strobe
//   tube_data    out  value shown on the seven-segment tube
//   halted       out  program has exited
module ecall_ctrl
  import ecall_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter int          SW_WIDTH        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [31:0]         a7,
  input  logic [31:0]         a0,
  input  logic                confirm_btn,
  input  logic [SW_WIDTH-1:0] sw_data,
  output logic                stop_flag,
  output logic [31:0]         io_wdata,
  output logic                io_wen,
  output logic [31:0]         tube_data,
  output logic                halted
);

  state_t state;
  state_t next_state;
  svc_t   svc;
  logic [31:0] arg;
  logic btn_level;
  logic btn_rise;
  logic signed [SW_WIDTH-1:0] sw_signed;
  logic [31:0] sw_ext;

  assign sw_signed = sw_data;
  assign sw_ext    = 32'(sw_signed);

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .raw  (confirm_btn),
    .level(btn_level),
    .rise (btn_rise)
  );

  // State register plus the values captured along the way. svc and arg are
  // latched only on the IDLE -> ECALL edge so that whatever a7/a0 do while
  // the core is frozen has no effect. io_wdata and tube_data change only on
  // the accepted press of their own service and hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      svc       <= SVC_NONE;
      arg       <= '0;
      io_wdata  <= '0;
      tube_data <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && opcode == ECALL) begin
        svc <= decode_svc(a7);
        arg <= a0;
      end
      if (state == WAIT_PRESS && btn_rise) begin
        if (svc == SVC_READ_INT) begin
          io_wdata <= sw_ext;
        end
        if (svc == SVC_PRINT_INT) begin
          tube_data <= arg;
        end
      end
    end
  end

  // Next-state and output decode. Outputs depend on the registered state
  // only, never on opcode. WAIT_RELEASE makes sure a press still held from
  // an earlier ECALL cannot be consumed; only a rising edge seen in
  // WAIT_PRESS counts. WRITE and RESUME both go straight back to IDLE
  // without looking at opcode, which keeps the ECALL that is still on the
  // bus in that cycle from firing a second time.
  always_comb begin
    next_state = state;
    stop_flag  = 1'b0;
    io_wen     = 1'b0;
    halted     = 1'b0;
    case (state)
      IDLE: begin
        if (opcode == ECALL) begin
          next_state = (decode_svc(a7) == SVC_NONE) ? RESUME : WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        stop_flag = 1'b1;
        if (!btn_level) begin
          next_state = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        stop_flag = 1'b1;
        if (btn_rise) begin
          case (svc)
            SVC_READ_INT: next_state = WRITE;
            SVC_EXIT:     next_state = HALT;
            default:      next_state = RESUME;
          endcase
        end
      end
      WRITE: begin
        io_wen     = 1'b1;
        next_state = IDLE;
      end
      RESUME: begin
        next_state = IDLE;
      end
      HALT: begin
        stop_flag = 1'b1;
        halted    = 1'b1;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ecall_ctrl.sv
// tb_ecall_ctrl
// Self-checking bench for ecall_ctrl with DEBOUNCE_CYCLES = 4: a table of
// per-cycle vectors for the basic read/print flows, hand sequences for the
// held-button, bounce, exit, reset and unknown-service cases, and randomized
// transactions checked against a transaction-level model.
module tb_ecall_ctrl;
  import ecall_ctrl_pkg::*;

  localparam int DC = 4;
  localparam logic [6:0]  NOP = 7'b0010011;
  localparam logic        H = 1'b1;
  localparam logic        L = 1'b0;
  localparam logic [31:0] Z = 32'd0;
  localparam logic [31:0] W = 32'hFFFF8001;
  localparam logic [31:0] T = 32'd1234;
  localparam logic [15:0] S = 16'h8001;
  localparam logic [15:0] S0 = 16'h0000;

  typedef struct packed {
    logic [6:0]  op;
    logic [31:0] a7v;
    logic [31:0] a0v;
    logic        btn;
    logic [15:0] sw;
    logic        stop;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] tube;
    logic        halt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [31:0] a7;
  logic [31:0] a0;
  logic        confirm_btn;
  logic [15:0] sw_data;
  logic        stop_flag;
  logic [31:0] io_wdata;
  logic        io_wen;
  logic [31:0] tube_data;
  logic        halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ecall_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .SW_WIDTH(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .a7         (a7),
    .a0         (a0),
    .confirm_btn(confirm_btn),
    .sw_data    (sw_data),
    .stop_flag  (stop_flag),
    .io_wdata   (io_wdata),
    .io_wen     (io_wen),
    .tube_data  (tube_data),
    .halted     (halted)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [31:0] a7v, input logic [31:0] a0v,
                               input logic btn, input logic [15:0] sw);
    opcode      = op;
    a7          = a7v;
    a0          = a0v;
    confirm_btn = btn;
    sw_data     = sw;
    step();
  endtask

  task automatic checkAll(input string tag, input logic stop, input logic wen, input logic [31:0] wd,
                          input logic [31:0] tube, input logic halt);
    checkOutput({tag, " stop_flag"}, {31'd0, stop_flag}, {31'd0, stop});
    checkOutput({tag, " io_wen"},    {31'd0, io_wen},    {31'd0, wen});
    checkOutput({tag, " io_wdata"},  io_wdata,           wd);
    checkOutput({tag, " tube_data"}, tube_data,          tube);
    checkOutput({tag, " halted"},    {31'd0, halted},    {31'd0, halt});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        vecs [19];
    logic [4:0]  bounce;
    logic [31:0] code;
    logic [31:0] arg;
    logic [15:0] sw;
    logic [31:0] exp_wdata;
    logic [31:0] exp_tube;
    int          pick;
    int          bursts;
    int          run_len;

    // ---------------- reset values ----------------
    reset = 1'b1;
    applyStimulus(NOP, Z, Z, L, S0);
    applyStimulus(NOP, Z, Z, L, S0);
    checkAll("reset", L, L, Z, Z, L);
    reset = 1'b0;

    // ---------------- table: read int then print int ----------------
    vecs = '{
      '{ECALL, 32'd5, Z,     L, S,  H, L, Z, Z, L},
      '{ECALL, 32'd5, Z,     H, S,  H, L, Z, Z, L},
      '{ECALL, 32'd1, Z,     H, S,  H, L, Z, Z, L},
      '{ECALL, 32'd1, Z,     H, S,  H, L, Z, Z, L},
      '{ECALL, 32'd1, Z,     H, S,  H, L, Z, Z, L},
      '{ECALL, 32'd1, Z,     H, S,  L, H, W, Z, L},
      '{NOP,   Z,     Z,     H, S,  L, L, W, Z, L},
      '{NOP,   Z,     Z,     L, S0, L, L, W, Z, L},
      '{NOP,   Z,     Z,     L, S0, L, L, W, Z, L},
      '{NOP,   Z,     Z,     L, S0, L, L, W, Z, L},
      '{NOP,   Z,     Z,     L, S0, L, L, W, Z, L},
      '{ECALL, 32'd1, T,     L, S0, H, L, W, Z, L},
      '{ECALL, 32'd1, T,     H, S0, H, L, W, Z, L},
      '{ECALL, 32'd5, 32'd99, H, S0, H, L, W, Z, L},
      '{ECALL, 32'd5, 32'd99, H, S0, H, L, W, Z, L},
      '{ECALL, 32'd5, 32'd99, H, S0, H, L, W, Z, L},
      '{ECALL, 32'd5, 32'd99, H, S0, L, L, W, T, L},
      '{ECALL, 32'd5, 32'd99, H, S0, L, L, W, T, L},
      '{NOP,   Z,     Z,     L, S0, L, L, W, T, L}
    };
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a7v, vecs[i].a0v, vecs[i].btn, vecs[i].sw);
      checkAll($sformatf("vec%0d", i), vecs[i].stop, vecs[i].wen, vecs[i].wdata, vecs[i].tube, vecs[i].halt);
    end

    // ---------------- button held across ECALL entry ----------------
    for (int i = 0; i < 5; i++) applyStimulus(NOP, Z, Z, H, 16'h1234);
    applyStimulus(ECALL, 32'd5, Z, H, 16'h1234);
    checkOutput("held entry stop", {31'd0, stop_flag}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(ECALL, 32'd5, Z, H, 16'h1234);
      checkOutput("held no service stop", {31'd0, stop_flag}, 32'd1);
      checkOutput("held no service wen", {31'd0, io_wen}, 32'd0);
    end
    for (int i = 0; i < DC; i++) begin
      applyStimulus(ECALL, 32'd5, Z, L, 16'h1234);
      checkOutput("held release stop", {31'd0, stop_flag}, 32'd1);
    end
    for (int k = 1; k <= DC + 1; k++) begin
      applyStimulus(ECALL, 32'd5, Z, H, 16'h1234);
      checkOutput("held press wen", {31'd0, io_wen}, (k == DC + 1) ? 32'd1 : 32'd0);
      checkOutput("held press stop", {31'd0, stop_flag}, (k == DC + 1) ? 32'd0 : 32'd1);
    end
    checkOutput("held wdata", io_wdata, 32'h0000_1234);
    applyStimulus(NOP, Z, Z, H, 16'h1234);
    checkOutput("held single pulse", {31'd0, io_wen}, 32'd0);
    for (int i = 0; i < DC; i++) applyStimulus(NOP, Z, Z, L, S0);

    // ---------------- bounce during WAIT_PRESS ----------------
    applyStimulus(ECALL, 32'd1, 32'hDEADBEEF, L, S0);
    bounce = 5'b10110;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(ECALL, 32'd1, 32'hDEADBEEF, (i < 5) ? bounce[4 - i] : L, S0);
      checkOutput("bounce stop", {31'd0, stop_flag}, 32'd1);
      checkOutput("bounce tube", tube_data, T);
    end
    for (int k = 1; k <= DC + 1; k++) begin
      applyStimulus(ECALL, 32'd1, 32'hDEADBEEF, H, S0);
      checkOutput("bounce press stop", {31'd0, stop_flag}, (k == DC + 1) ? 32'd0 : 32'd1);
    end
    checkOutput("bounce press tube", tube_data, 32'hDEADBEEF);
    applyStimulus(NOP, Z, Z, H, S0);
    for (int i = 0; i < DC; i++) applyStimulus(NOP, Z, Z, L, S0);

    // ---------------- exit halts until reset ----------------
    applyStimulus(ECALL, 32'd10, Z, L, S0);
    for (int k = 1; k <= DC + 1; k++) begin
      applyStimulus(ECALL, 32'd10, Z, H, S0);
      checkOutput("exit halted", {31'd0, halted}, (k == DC + 1) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(($urandom_range(0, 1) == 1) ? ECALL : NOP, 32'($urandom_range(0, 12)), $urandom,
                    1'($urandom_range(0, 1)), 16'($urandom));
      checkOutput("halt stop", {31'd0, stop_flag}, 32'd1);
      checkOutput("halt halted", {31'd0, halted}, 32'd1);
      checkOutput("halt wen", {31'd0, io_wen}, 32'd0);
    end
    reset = 1'b1;
    applyStimulus(NOP, Z, Z, L, S0);
    reset = 1'b0;
    checkAll("halt reset", L, L, Z, Z, L);

    // ---------------- reset during service, then unknown service ----------------
    applyStimulus(ECALL, 32'd5, Z, L, 16'hABCD);
    for (int k = 1; k <= DC; k++) begin
      applyStimulus(ECALL, 32'd5, Z, H, 16'hABCD);
      checkOutput("abort press stop", {31'd0, stop_flag}, 32'd1);
    end
    reset = 1'b1;
    applyStimulus(ECALL, 32'd5, Z, H, 16'hABCD);
    reset = 1'b0;
    checkAll("abort reset", L, L, Z, Z, L);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(NOP, Z, Z, H, 16'hABCD);
      checkOutput("abort no pulse", {31'd0, io_wen}, 32'd0);
      checkOutput("abort idle stop", {31'd0, stop_flag}, 32'd0);
    end
    for (int i = 0; i < DC; i++) applyStimulus(NOP, Z, Z, L, S0);
    applyStimulus(ECALL, 32'd7, Z, L, S0);
    checkOutput("unknown resume stop", {31'd0, stop_flag}, 32'd0);
    applyStimulus(ECALL, 32'd5, Z, L, S0);
    checkOutput("unknown no retrigger", {31'd0, stop_flag}, 32'd0);
    applyStimulus(NOP, Z, Z, L, S0);
    checkOutput("unknown idle stop", {31'd0, stop_flag}, 32'd0);

    // ---------------- randomized transactions vs model ----------------
    // Model: a service fires on the (DC+1)-th consecutive high sample of a
    // press that starts after a released button; read stores sext(sw), print
    // stores a0 as latched at ECALL, unknown codes never stall the core.
    reset = 1'b1;
    applyStimulus(NOP, Z, Z, L, S0);
    reset = 1'b0;
    exp_wdata = 32'd0;
    exp_tube  = 32'd0;
    for (int t = 0; t < 14; t++) begin
      pick = $urandom_range(0, 2);
      code = (pick == 0) ? 32'd1 : (pick == 1) ? 32'd5 : 32'($urandom_range(11, 1000));
      arg  = $urandom;
      sw   = 16'($urandom);
      applyStimulus(ECALL, code, arg, L, sw);
      if (pick == 2) begin
        checkOutput("rnd unknown stop", {31'd0, stop_flag}, 32'd0);
        applyStimulus(NOP, Z, Z, L, sw);
        checkOutput("rnd unknown idle", {31'd0, stop_flag}, 32'd0);
      end else begin
        checkOutput("rnd entry stop", {31'd0, stop_flag}, 32'd1);
        bursts = $urandom_range(0, 3);
        for (int b = 0; b < bursts; b++) begin
          run_len = $urandom_range(1, DC - 1);
          for (int i = 0; i < run_len; i++) begin
            applyStimulus(ECALL, $urandom, $urandom, H, sw);
            checkOutput("rnd noise stop", {31'd0, stop_flag}, 32'd1);
            checkOutput("rnd noise wen", {31'd0, io_wen}, 32'd0);
          end
          run_len = $urandom_range(1, 3);
          for (int i = 0; i < run_len; i++) begin
            applyStimulus(ECALL, $urandom, $urandom, L, sw);
            checkOutput("rnd gap stop", {31'd0, stop_flag}, 32'd1);
          end
        end
        for (int k = 1; k <= DC + 1; k++) begin
          applyStimulus(ECALL, $urandom, $urandom, H, sw);
          if (k == DC + 1) begin
            if (code == 32'd5) exp_wdata = {{16{sw[15]}}, sw};
            if (code == 32'd1) exp_tube = arg;
          end
          checkOutput("rnd press stop", {31'd0, stop_flag}, (k == DC + 1) ? 32'd0 : 32'd1);
          checkOutput("rnd press wen", {31'd0, io_wen}, (k == DC + 1 && code == 32'd5) ? 32'd1 : 32'd0);
          checkOutput("rnd press wdata", io_wdata, exp_wdata);
          checkOutput("rnd press tube", tube_data, exp_tube);
        end
        applyStimulus(NOP, Z, Z, H, 16'($urandom));
        checkOutput("rnd after stop", {31'd0, stop_flag}, 32'd0);
        checkOutput("rnd after wen", {31'd0, io_wen}, 32'd0);
        for (int i = 0; i < DC; i++) applyStimulus(NOP, Z, Z, L, 16'($urandom));
        checkOutput("rnd hold wdata", io_wdata, exp_wdata);
        checkOutput("rnd hold tube", tube_data, exp_tube);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
